// File: rtl/instruction_sequencer.sv
// Program buffer and issue engine for the cpu block: loads a program, issues it
// one word per clock with post-operate NOP bubbles, and queues READ results.
module instruction_sequencer #(
    parameter int unsigned PROGRAM_DEPTH        = 32,
    parameter int unsigned RESULT_FIFO_DEPTH    = 4,
    parameter int unsigned OPERATE_STALL_CYCLES = 4
) (
    input  logic               clock_in,
    input  logic               reset_n_in,
    input  logic               load_valid_in,
    input  logic [31:0]        load_instruction_in,
    output logic               load_ready_out,
    input  logic               clear_in,
    input  logic               start_in,
    output logic               busy_out,
    output logic               done_out,
    output logic [31:0]        current_instruction_out,
    input  logic signed [7:0]  cpu_output_in,
    output logic               result_valid_out,
    input  logic               result_ready_in,
    output logic signed [7:0]  result_data_out
);

    localparam int unsigned PW  = $clog2(PROGRAM_DEPTH + 1);
    localparam int unsigned AW  = (PROGRAM_DEPTH > 1) ? $clog2(PROGRAM_DEPTH) : 1;
    localparam int unsigned WW  = (OPERATE_STALL_CYCLES > 0) ? $clog2(OPERATE_STALL_CYCLES + 1) : 1;
    localparam int unsigned FAW = (RESULT_FIFO_DEPTH > 1) ? $clog2(RESULT_FIFO_DEPTH) : 1;
    localparam int unsigned FCW = $clog2(RESULT_FIFO_DEPTH + 1);

    localparam logic [7:0]  OP_OPERATE     = 8'h05;
    localparam logic [7:0]  OP_READ_CPU    = 8'h0F;
    localparam logic [7:0]  OP_READ_TENSOR = 8'h10;
    localparam logic [31:0] NOP_WORD       = 32'h0000_0008;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_OPWAIT
    } state_t;

    state_t            r_state;
    logic [PW-1:0]     r_count;
    logic [PW-1:0]     r_pc;
    logic [WW-1:0]     r_wait;
    logic              r_done;
    logic [31:0]       r_mem [PROGRAM_DEPTH];

    logic signed [7:0] r_fifo [RESULT_FIFO_DEPTH];
    logic [FAW-1:0]    r_wr_ptr;
    logic [FAW-1:0]    r_rd_ptr;
    logic [FCW-1:0]    r_fifo_count;

    state_t            w_next_state;
    logic [PW-1:0]     w_count_next;
    logic [PW-1:0]     w_pc_next;
    logic [WW-1:0]     w_wait_next;
    logic              w_done_next;
    logic              w_push;
    logic              w_pop;
    logic              w_mem_we;
    logic              w_load_ready;
    logic [31:0]       w_instr;
    logic [31:0]       w_cur_word;
    logic              w_is_read;
    logic              w_is_operate;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic              w_stall;
    logic              w_last;

    function automatic logic [FAW-1:0] f_ptr_inc(input logic [FAW-1:0] p);
        return (p == FAW'(RESULT_FIFO_DEPTH - 1)) ? '0 : p + FAW'(1);
    endfunction

    assign w_cur_word   = r_mem[r_pc[AW-1:0]];
    assign w_is_read    = (w_cur_word[7:0] == OP_READ_CPU) || (w_cur_word[7:0] == OP_READ_TENSOR);
    assign w_is_operate = (w_cur_word[7:0] == OP_OPERATE);
    assign w_fifo_full  = (r_fifo_count == FCW'(RESULT_FIFO_DEPTH));
    assign w_fifo_empty = (r_fifo_count == '0);
    // Full flag is the registered one, so a same-cycle pop cannot release the stall.
    assign w_stall      = w_is_read && w_fifo_full;
    assign w_last       = (r_pc == r_count - PW'(1));
    assign w_pop        = !w_fifo_empty && result_ready_in;

    always_comb begin
        w_next_state = r_state;
        w_count_next = r_count;
        w_pc_next    = r_pc;
        w_wait_next  = r_wait;
        w_done_next  = 1'b0;
        w_push       = 1'b0;
        w_mem_we     = 1'b0;
        w_load_ready = 1'b0;
        w_instr      = NOP_WORD;
        case (r_state)
            S_IDLE: begin
                w_load_ready = (r_count < PW'(PROGRAM_DEPTH));
                if (clear_in) begin
                    w_count_next = '0;
                end else if (load_valid_in && w_load_ready) begin
                    w_mem_we     = 1'b1;
                    w_count_next = r_count + PW'(1);
                end
                if (start_in) begin
                    if (clear_in || (r_count == '0)) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_pc_next    = '0;
                        w_next_state = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!w_stall) begin
                    w_instr = w_cur_word;
                    w_push  = w_is_read;
                    if (w_is_operate && (OPERATE_STALL_CYCLES != 0)) begin
                        w_next_state = S_OPWAIT;
                        w_wait_next  = WW'(OPERATE_STALL_CYCLES);
                    end else if (w_last) begin
                        w_next_state = S_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_pc_next = r_pc + PW'(1);
                    end
                end
            end
            S_OPWAIT: begin
                // pc still points at the operate; the advance happens on leaving OPWAIT.
                w_wait_next = r_wait - WW'(1);
                if (r_wait <= WW'(1)) begin
                    if (w_last) begin
                        w_next_state = S_IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_next_state = S_RUN;
                        w_pc_next    = r_pc + PW'(1);
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_pc    <= '0;
            r_wait  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_count_next;
            r_pc    <= w_pc_next;
            r_wait  <= w_wait_next;
            r_done  <= w_done_next;
        end
    end

    always_ff @(posedge clock_in) begin
        if (w_mem_we) begin
            r_mem[r_count[AW-1:0]] <= load_instruction_in;
        end
        if (w_push) begin
            r_fifo[r_wr_ptr] <= cpu_output_in;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fifo_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= f_ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= f_ptr_inc(r_rd_ptr);
            end
            if (w_push && !w_pop) begin
                r_fifo_count <= r_fifo_count + FCW'(1);
            end else if (w_pop && !w_push) begin
                r_fifo_count <= r_fifo_count - FCW'(1);
            end
        end
    end

    assign load_ready_out          = w_load_ready;
    assign busy_out                = (r_state != S_IDLE);
    assign done_out                = r_done;
    assign current_instruction_out = w_instr;
    assign result_valid_out        = !w_fifo_empty;
    assign result_data_out         = w_fifo_empty ? 8'sd0 : r_fifo[r_rd_ptr];

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench: stimulus queues expected instructions, results and done pulses;
// a negedge monitor compares them as the sequencer presents each output.
module tb_instruction_sequencer;

    localparam logic [31:0] NOP = 32'h0000_0008;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              load_valid = 1'b0;
    logic [31:0]       load_instr = '0;
    logic              load_ready;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic [31:0]       cur;
    logic signed [7:0] cpu_out;
    logic              res_valid;
    logic              res_ready = 1'b1;
    logic signed [7:0] res_data;
    logic              cpu_sel = 1'b0;

    int checks = 0;
    int errors = 0;
    int done_seen = 0;
    int exp_done = 0;
    logic [31:0]       exp_instr[$];
    logic signed [7:0] exp_res[$];

    instruction_sequencer #(
        .PROGRAM_DEPTH(32),
        .RESULT_FIFO_DEPTH(4),
        .OPERATE_STALL_CYCLES(4)
    ) dut (
        .clock_in(clk),
        .reset_n_in(rst_n),
        .load_valid_in(load_valid),
        .load_instruction_in(load_instr),
        .load_ready_out(load_ready),
        .clear_in(clear),
        .start_in(start),
        .busy_out(busy),
        .done_out(done),
        .current_instruction_out(cur),
        .cpu_output_in(cpu_out),
        .result_valid_out(res_valid),
        .result_ready_in(res_ready),
        .result_data_out(res_data)
    );

    always #5 clk = ~clk;

    // cpu stand-in: READ opcodes return 5, or bits [23:16] of the word when cpu_sel is set
    assign cpu_out = ((cur[7:0] == 8'h0F) || (cur[7:0] == 8'h10))
                     ? (cpu_sel ? $signed(cur[23:16]) : 8'sd5) : 8'sd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) begin
                if (exp_instr.size() == 0) chk("instr_extra", cur, 32'hFFFF_FFFF);
                else chk("instr", cur, exp_instr.pop_front());
            end else begin
                chk("instr_idle", cur, NOP);
            end
            if (res_valid && res_ready) begin
                if (exp_res.size() == 0) chk("result_extra", 32'(res_data), 32'hFFFF_FFFF);
                else chk("result", 32'(res_data), 32'(exp_res.pop_front()));
            end
            if (done) begin
                done_seen++;
                chk("done_not_busy", 32'(busy), 32'd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w);
        chk("load_ready_before_load", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_instr = w;
        step();
        load_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    task automatic do_start();
        exp_done++;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while ((done_seen < exp_done || busy) && n < budget) begin
            step();
            n++;
        end
        step();
        chk({name, "_done_count"}, 32'(done_seen), 32'(exp_done));
        chk({name, "_instr_drained"}, 32'(exp_instr.size()), 32'd0);
    endtask

    task automatic wait_results(input string name, input int budget);
        int n = 0;
        while (exp_res.size() != 0 && n < budget) begin
            step();
            n++;
        end
        chk({name, "_results_drained"}, 32'(exp_res.size()), 32'd0);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_instr", cur, NOP);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_load_ready", 32'(load_ready), 32'd1);

        // basic run
        load_word(32'h0100_0509);
        load_word(32'h0001_000F);
        load_word(32'h0000_0008);
        exp_instr.push_back(32'h0100_0509);
        exp_instr.push_back(32'h0001_000F);
        exp_instr.push_back(32'h0000_0008);
        exp_res.push_back(8'sd5);
        do_start();
        wait_done("basic", 20);
        wait_results("basic", 10);

        // rerun of the retained program
        exp_instr.push_back(32'h0100_0509);
        exp_instr.push_back(32'h0001_000F);
        exp_instr.push_back(32'h0000_0008);
        exp_res.push_back(8'sd5);
        do_start();
        wait_done("rerun", 20);
        wait_results("rerun", 10);

        // operate bubble
        do_clear();
        load_word(32'h0000_0005);
        load_word(32'h0100_0509);
        exp_instr.push_back(32'h0000_0005);
        repeat (4) exp_instr.push_back(NOP);
        exp_instr.push_back(32'h0100_0509);
        do_start();
        wait_done("operate", 30);

        // FIFO backpressure
        do_clear();
        for (int i = 1; i <= 6; i++) load_word({8'h00, 8'(i), 16'h000F});
        cpu_sel = 1'b1;
        res_ready = 1'b0;
        for (int i = 1; i <= 4; i++) exp_instr.push_back({8'h00, 8'(i), 16'h000F});
        repeat (4) exp_instr.push_back(NOP);
        exp_instr.push_back(32'h0005_000F);
        exp_instr.push_back(32'h0006_000F);
        for (int i = 1; i <= 6; i++) exp_res.push_back(8'(i));
        do_start();
        repeat (7) step();
        chk("bp_valid_while_full", 32'(res_valid), 32'd1);
        chk("bp_stalled_busy", 32'(busy), 32'd1);
        res_ready = 1'b1;
        wait_done("backpressure", 30);
        wait_results("backpressure", 20);
        cpu_sel = 1'b0;

        // load limits: 33 offered, only 32 stored
        do_clear();
        for (int i = 0; i < 32; i++) load_word({16'h0000, 8'(i), 8'h08});
        chk("full_load_ready", 32'(load_ready), 32'd0);
        load_valid = 1'b1;
        load_instr = 32'hDEAD_0008;
        step();
        load_valid = 1'b0;
        for (int i = 0; i < 32; i++) exp_instr.push_back({16'h0000, 8'(i), 8'h08});
        do_start();
        wait_done("depth", 60);
        do_clear();
        chk("cleared_load_ready", 32'(load_ready), 32'd1);
        do_start();
        wait_done("empty_start", 10);

        // clear and start together: clear wins, empty start
        load_word(32'h0100_0509);
        clear = 1'b1;
        exp_done++;
        start = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b0;
        wait_done("clear_start", 10);

        // reset in the second RUN cycle with one result queued
        do_clear();
        load_word(32'h0001_000F);
        repeat (3) load_word(NOP);
        res_ready = 1'b0;
        exp_instr.push_back(32'h0001_000F);
        do_start();
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst_instr", cur, NOP);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_valid", 32'(res_valid), 32'd0);
        chk("midrst_data", 32'(res_data), 32'd0);
        exp_done--;
        step();
        rst_n = 1'b1;
        res_ready = 1'b1;
        step();
        do_start();
        wait_done("after_reset", 10);

        chk("final_results_drained", 32'(exp_res.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/instruction_sequencer.md
# instruction_sequencer

Program buffer and issue engine that drives the `cpu` block's 32-bit `current_instruction` port and collects its `cpu_output`. The block has four jobs:
- Accept a program over a valid/ready load port.
- Issue the program one instruction per clock when started.
- Insert NOP bubbles after tensor-core operate instructions.
- Capture the CPU result for every READ instruction into a result FIFO with a valid/ready handshake.

## Interface

Parameters:
- `PROGRAM_DEPTH`, 32: number of instruction slots.
- `RESULT_FIFO_DEPTH`, 4: number of result FIFO entries.
- `OPERATE_STALL_CYCLES`, 4: number of NOP cycles inserted after `TENSOR_CORE_OPERATE`.

Ports:
- `clock_in`, input, 1: single clock; all state changes on the rising edge.
- `reset_n_in`, input, 1: reset, asynchronous, active-low.
- `load_valid_in`, input, 1: a program word is offered.
- `load_instruction_in`, input, 32: the program word.
- `load_ready_out`, output, 1: the block can accept a word.
- `clear_in`, input, 1: empties the program buffer; honoured only in IDLE.
- `start_in`, input, 1: begin execution; honoured only in IDLE.
- `busy_out`, output, 1: high while not in IDLE.
- `done_out`, output, 1: one-cycle pulse at the end of a run.
- `current_instruction_out`, output, 32: instruction presented to the cpu.
- `cpu_output_in`, input, signed 8: combinational result returned from the cpu.
- `result_valid_out`, output, 1: result FIFO is non-empty.
- `result_ready_in`, input, 1: consumer accepts the head entry.
- `result_data_out`, output, signed 8: head entry of the result FIFO.

## Operation

Opcode constants (instruction bits [7:0]):
- `TENSOR_CORE_OPERATE` = 0x05
- `NOP` = 0x08
- `READ_CPU` = 0x0F
- `READ_TENSOR_CORE` = 0x10
- The NOP word is 0x00000008.

State machine: IDLE, RUN, OPWAIT.

IDLE:
- `current_instruction_out` = NOP.
- `load_ready_out` = (count < `PROGRAM_DEPTH`).
- Load handshake: when `load_valid_in` and `load_ready_out` are both high, write `mem[count]` and increment count.
- `clear_in` sets count = 0. It has priority over a load in the same cycle.
- `start_in` with count > 0: set pc = 0 and go to RUN.
- `start_in` with count == 0: pulse `done_out` next cycle and stay in IDLE.
- `start_in` and `clear_in` together: clear wins, and start is treated as an empty-program start.

RUN:
- `load_ready_out` = 0. `start_in` and `clear_in` are ignored.
- Presented word: `current_instruction_out` = `mem[pc]` unless stalled.
- Stall condition: `mem[pc]` is a READ opcode and the FIFO is full, using the full flag registered at the start of the cycle.
- While stalled: present NOP and hold pc. A pop in the same cycle does not unstall until the next cycle.
- Non-stalled READ: on the clock edge, push `cpu_output_in` into the FIFO.
- `TENSOR_CORE_OPERATE`: present it for one cycle, then go to OPWAIT with a wait counter of `OPERATE_STALL_CYCLES`.
- Advance: after any issued instruction, pc increments.
- End of run: if pc == count − 1, go to IDLE and pulse `done_out`. An operate in the last slot completes its OPWAIT first.

OPWAIT:
- Present NOP and decrement the wait counter.
- At zero, return to RUN at the next pc, or go to IDLE plus `done_out` if the program is finished.

Program retention: count and `mem` persist after a run, so a second `start_in` reruns the same program.

Result FIFO:
- In-order circular buffer.
- `result_data_out` is the head entry; `result_valid_out` = !empty.
- A pop happens when valid and `result_ready_in` are both high.
- A push and pop in the same cycle leave the occupancy unchanged.
- Pointers wrap modulo `RESULT_FIFO_DEPTH`. The FIFO persists across IDLE.

Widths:
- pc and count: clog2(`PROGRAM_DEPTH` + 1) bits.
- Wait counter: clog2(`OPERATE_STALL_CYCLES` + 1) bits.
- FIFO data is stored unmodified (signed 8).

## Timing

- Reset (async assert, synchronous-safe deassert) puts every output in a defined state:
  - State IDLE; count, pc and the FIFO cleared.
  - `current_instruction_out` = 0x00000008.
  - `busy_out` = 0, `done_out` = 0, `result_valid_out` = 0, `result_data_out` = 0.
  - `load_ready_out` = 1 once reset is released.
  - `mem` contents are not reset.
- Reset mid-run: outputs return to the reset values immediately (combinationally after assert).
- Start latency: `start_in` is sampled at edge T. Instruction 0 is presented during cycle T+1 and `busy_out` is high from T+1.
- Throughput: one instruction per cycle with no stalls. An N-instruction program without operates or stalls occupies N cycles.
- Done: `done_out` is high for exactly the one cycle after the last instruction or OPWAIT cycle, coincident with `busy_out` = 0.
- Result capture: `cpu_output_in` is sampled at the edge that ends the READ cycle. `result_valid_out` rises in the next cycle.

## Test plan

- **Basic run.** Load 0x01000509, 0x0001000F, 0x00000008. Pulse start. Bench drives `cpu_output_in` = 5 during the READ.
  - Required: the three words are presented in cycles 1–3 after start.
  - Required: `result_data_out` = 5 with valid in cycle 3.
  - Required: `done_out` in cycle 4, then `busy_out` = 0.
- **FIFO backpressure.** Load six READ_CPU words, `cpu_output_in` = 1..6, `result_ready_in` = 0.
  - Required: four pushes, then NOP presented with pc frozen.
  - Raise ready: required that the remaining two issue and six results pop in order 1..6.
- **Operate bubble.** Load 0x00000005, 0x01000509.
  - Required: operate presented for 1 cycle, NOP for 4 cycles, then ADD_IMM, then `done_out`.
- **Load limits.**
  - Offer 33 words: required that `load_ready_out` drops after the 32nd and word 33 is not stored.
  - Pulse `clear_in`: required that ready returns; a following start gives an immediate `done_out` and only NOPs.
- **Reset mid-run.** Assert `reset_n_in` low in the 2nd RUN cycle with one result queued.
  - Required: NOP output, `busy_out` = 0 and `result_valid_out` = 0 immediately.
  - Required: start after release gives only `done_out`.
- **Rerun.** Start again after the basic run.
  - Required: the identical instruction sequence and a second result of 5.
